ei_axi4_slave_mem: RTL
======================

// Module: ei_axi4_slave_mem
// PURPOSE
//  Parametrised synthesizable AXI4 slave memory; replaces fixed-width slave model behind ei_axi4_interconnect.
//  Independent write (AW/W/B) and read (AR/R) engines; FIXED/INCR/WRAP bursts, byte strobes, one outstanding txn per direction.
//  Single-ID, in-order; no ID ports.
// PARAMETERS
//  DATA_W     32    data bus width, 8..1024, power of 2
//  ADDR_W     32    address width
//  MEM_BYTES  4096  memory size in bytes, power of 2, multiple of DATA_W/8
// PORTS
//  aclk     in   1            clock, all logic on posedge
//  areset   in   1            async active-high reset
//  awaddr   in   ADDR_W       write burst start address
//  awlen    in   8            beats-1
//  awsize   in   3            log2 bytes/beat, must be <= log2(DATA_W/8)
//  awburst  in   2            00 FIXED, 01 INCR, 10 WRAP
//  awvalid  in   1            AW valid
//  awready  out  1            AW ready
//  wdata    in   DATA_W       write data
//  wstrb    in   DATA_W/8     byte enables
//  wlast    in   1            last write beat
//  wvalid   in   1            W valid
//  wready   out  1            W ready
//  bresp    out  2            write response
//  bvalid   out  1            B valid
//  bready   in   1            B ready
//  araddr   in   ADDR_W       read burst start address
//  arlen    in   8            beats-1
//  arsize   in   3            log2 bytes/beat
//  arburst  in   2            burst type
//  arvalid  in   1            AR valid
//  arready  out  1            AR ready
//  rdata    out  DATA_W       read data
//  rresp    out  2            read response
//  rlast    out  1            last read beat
//  rvalid   out  1            R valid
//  rready   in   1            R ready
// BEHAVIOUR
//  Reset: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=rresp=00, rdata=0; FSMs -> IDLE; memory array not reset.
//  Write FSM W_IDLE->W_DATA on awvalid&&awready (latch addr/len/size/burst, beat cnt=0, awready=0, wready=1).
//  W_DATA: each wvalid&&wready commits bytes with wstrb=1 same cycle; after beat awlen+1 -> W_RESP (wready=0, bvalid=1 next cycle).
//  W_RESP -> W_IDLE on bvalid&&bready; awready=1 the following cycle.
//  Read FSM R_IDLE->R_DATA on arvalid&&arready; first rvalid cycle after AR handshake; next beat cycle after each rvalid&&rready (full throughput).
//  rdata/rresp/rlast stable while rvalid&&!rready; rlast=1 on beat arlen+1 only; last handshake -> R_IDLE, arready=1 next cycle.
//  Address step: FIXED none; INCR aligned(addr)+2^size; WRAP wraps within boundary (len+1)<<size; WRAP len not in {1,3,7,15} and reserved 11 treated as INCR.
//  Beats may cross 4KB; byte lane = addr mod (DATA_W/8); unaligned first beat writes only lanes >= addr offset.
//  Same-cycle write commit and read beat launch to same address: read returns old data.
//  Reset mid-burst: burst abandoned, partial writes retained, no response issued.
// CONFIGURATION
//  EI_AXI4_SLV_ERR_EN undefined: addr taken modulo MEM_BYTES; resp always OKAY(00); wlast ignored, length from awlen.
//  EI_AXI4_SLV_ERR_EN defined: beat addr >= MEM_BYTES, reserved burst, illegal WRAP len or wlast != (last beat) -> SLVERR(10).
//    Out-of-range write beat dropped, read beat rdata=0; bresp sticky SLVERR if any beat erred; rresp per beat.
// STRUCTURE
//  ei_axi4_pkg: burst_e {FIXED,INCR,WRAP}, resp_e {OKAY,EXOKAY,SLVERR,DECERR}, wr_state_e, rd_state_e.
//  ei_axi4_pkg: function next_addr(addr, size, len, burst).
//  Sub-module ei_axi4_burst_addr_gen instantiated twice (write, read engines).
// TESTING
//  AW INCR addr 0x10 len 3 size 2, 4 beats 0xA0..0xA3 all strb -> bresp 00 after 4th beat; AR same -> rdata A0..A3, rlast beat 4.
//  WRAP addr 0x38 len 3 size 2 -> beat addrs 0x38,0x3C,0x30,0x34.
//  Write 0x11223344 @0x0 then strb 0101 data 0xFFFFFFFF -> readback 0x11FF33FF.
//  rready low 5 cycles mid-burst -> rdata/rlast unchanged; bready low -> bvalid held, awready stays 0.
//  areset pulse during beat 2 of 4-beat write -> no bvalid, awready=1 after release; beat 1 readable.
//  ERR_EN: write addr MEM_BYTES len 0 -> bresp 10, mem unchanged; without macro -> writes addr 0, bresp 00.

Source files
------------

// File: rtl/ei_axi4_slave_mem_pkg.sv
// Shared AXI4 slave types and burst address arithmetic for the slave memory.
package ei_axi4_pkg;

  typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10} burst_e;
  typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} resp_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;

  localparam int unsigned AXI_ADDR_MAX = 64;
  typedef logic [AXI_ADDR_MAX-1:0] axi_addr_t;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return len inside {8'd1, 8'd3, 8'd7, 8'd15};
  endfunction

  function automatic logic burst_illegal(input logic [7:0] len, input logic [1:0] burst);
    return (burst == 2'b11) || ((burst == WRAP) && !wrap_len_ok(len));
  endfunction

  // Reserved burst type and WRAP with an unsupported length both step like INCR.
  function automatic axi_addr_t next_addr(input axi_addr_t addr, input logic [2:0] size,
                                          input logic [7:0] len, input logic [1:0] burst);
    axi_addr_t bytes, aligned, span;
    bytes   = axi_addr_t'(1) << size;
    aligned = addr & ~(bytes - axi_addr_t'(1));
    span    = (axi_addr_t'(len) + axi_addr_t'(1)) << size;
    if (burst == FIXED) return addr;
    if ((burst == WRAP) && wrap_len_ok(len))
      return (addr & ~(span - axi_addr_t'(1))) | ((aligned + bytes) & (span - axi_addr_t'(1)));
    return aligned + bytes;
  endfunction

endpackage

// File: rtl/ei_axi4_slave_mem_if.sv
// Single-ID AXI4 bus bundle between a master and ei_axi4_slave_mem.
interface ei_axi4_slave_mem_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output araddr, arlen, arsize, arburst, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/ei_axi4_slave_mem_addr_gen.sv
// Burst beat address/counter tracker; one instance per direction of ei_axi4_slave_mem.
module ei_axi4_burst_addr_gen
  import ei_axi4_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [7:0]        start_len,
  input  logic [2:0]        start_size,
  input  logic [1:0]        start_burst,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] addr_next,
  output logic [2:0]        size,
  output logic              last,
  output logic              illegal
);
  logic [7:0] len;
  logic [7:0] cnt;
  logic [1:0] burst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr  <= '0;
      len   <= '0;
      size  <= '0;
      burst <= '0;
      cnt   <= '0;
    end else if (load) begin
      addr  <= start_addr;
      len   <= start_len;
      size  <= start_size;
      burst <= start_burst;
      cnt   <= '0;
    end else if (step) begin
      addr  <= addr_next;
      cnt   <= cnt + 8'd1;
    end
  end

  assign addr_next = ADDR_W'(next_addr(axi_addr_t'(addr), size, len, burst));
  assign last      = (cnt == len);
  assign illegal   = burst_illegal(len, burst);

endmodule

// File: rtl/ei_axi4_slave_mem.sv
// AXI4 slave memory with independent write and read burst engines.
// Define EI_AXI4_SLV_ERR_EN to report SLVERR for out-of-range, illegal-burst and wlast errors.
module ei_axi4_slave_mem
  import ei_axi4_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_BYTES = 4096
) (
  input logic                aclk,
  input logic                areset,
  ei_axi4_slave_mem_if.slave bus
);
  localparam int unsigned BB     = DATA_W / 8;
  localparam int unsigned MEM_AW = $clog2(MEM_BYTES);

  logic [7:0] mem [MEM_BYTES];

  // Valid lanes of a (possibly narrow or unaligned) beat within the bus word.
  function automatic logic [BB-1:0] lane_mask(input logic [ADDR_W-1:0] a, input logic [2:0] sz);
    logic [BB-1:0] m;
    int unsigned   off, nb, hi;
    off = 32'(a[MEM_AW-1:0]) % BB;
    nb  = 32'd1 << sz;
    hi  = (off & ~(nb - 32'd1)) + nb;
    m   = '0;
    for (int unsigned l = 0; l < BB; l++) m[l] = (l >= off) && (l < hi);
    return m;
  endfunction

  wr_state_e         wr_state, wr_next;
  logic              awready, wready, bvalid, aw_fire, w_fire;
  logic [ADDR_W-1:0] wr_addr, unused_wr_next;
  logic [2:0]        wr_size;
  logic              wr_last, wr_illegal, wr_err, wr_oob, wr_sticky;
  logic [BB-1:0]     wr_lanes;
  logic [MEM_AW-1:0] wr_base;

  rd_state_e         rd_state, rd_next;
  logic              arready, rvalid, ar_fire, r_fire, rd_launch;
  logic [ADDR_W-1:0] rd_addr, rd_addr_next, rl_addr;
  logic [2:0]        unused_rd_size;
  logic              rd_last, rd_illegal, rl_illegal, rl_err, rd_oob;
  logic [MEM_AW-1:0] rl_base;
  logic [DATA_W-1:0] rl_word, rdata_q;
  logic [1:0]        rresp_q;

  ei_axi4_burst_addr_gen #(.ADDR_W(ADDR_W)) u_wr_gen (
    .clk(aclk), .rst(areset), .load(aw_fire), .step(w_fire),
    .start_addr(bus.awaddr), .start_len(bus.awlen), .start_size(bus.awsize), .start_burst(bus.awburst),
    .addr(wr_addr), .addr_next(unused_wr_next), .size(wr_size), .last(wr_last), .illegal(wr_illegal)
  );

  ei_axi4_burst_addr_gen #(.ADDR_W(ADDR_W)) u_rd_gen (
    .clk(aclk), .rst(areset), .load(ar_fire), .step(r_fire),
    .start_addr(bus.araddr), .start_len(bus.arlen), .start_size(bus.arsize), .start_burst(bus.arburst),
    .addr(rd_addr), .addr_next(rd_addr_next), .size(unused_rd_size), .last(rd_last), .illegal(rd_illegal)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) wr_state <= W_IDLE;
    else        wr_state <= wr_next;
  end

  always_comb begin
    wr_next = wr_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (wr_state)
      W_IDLE: begin
        awready = 1'b1;
        if (bus.awvalid) wr_next = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (bus.wvalid && wr_last) wr_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bus.bready) wr_next = W_IDLE;
      end
      default: wr_next = W_IDLE;
    endcase
  end

  assign aw_fire  = awready && bus.awvalid;
  assign w_fire   = wready && bus.wvalid;
  assign wr_base  = wr_addr[MEM_AW-1:0] & ~MEM_AW'(BB - 1);
  assign wr_lanes = lane_mask(wr_addr, wr_size) & bus.wstrb & {BB{!wr_oob}};

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)                 wr_sticky <= 1'b0;
    else if (aw_fire)           wr_sticky <= 1'b0;
    else if (w_fire && wr_err)  wr_sticky <= 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (w_fire) begin
      for (int unsigned l = 0; l < BB; l++)
        if (wr_lanes[l]) mem[wr_base + MEM_AW'(l)] <= bus.wdata[8*l +: 8];
    end
  end

  assign bus.awready = awready;
  assign bus.wready  = wready;
  assign bus.bvalid  = bvalid;
  assign bus.bresp   = (bvalid && wr_sticky) ? SLVERR : OKAY;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) rd_state <= R_IDLE;
    else        rd_state <= rd_next;
  end

  always_comb begin
    rd_next = rd_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    case (rd_state)
      R_IDLE: begin
        arready = 1'b1;
        if (bus.arvalid) rd_next = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (bus.rready && rd_last) rd_next = R_IDLE;
      end
      default: rd_next = R_IDLE;
    endcase
  end

  // Beat data is fetched one cycle ahead and held in rdata_q, so a write committing
  // on the launch edge is not visible and a stalled beat cannot change under the master.
  assign ar_fire    = arready && bus.arvalid;
  assign r_fire     = rvalid && bus.rready;
  assign rd_launch  = ar_fire || (r_fire && !rd_last);
  assign rl_addr    = (rd_state == R_IDLE) ? bus.araddr : rd_addr_next;
  assign rl_illegal = (rd_state == R_IDLE) ? burst_illegal(bus.arlen, bus.arburst) : rd_illegal;
  assign rl_base    = rl_addr[MEM_AW-1:0] & ~MEM_AW'(BB - 1);

  always_comb begin
    rl_word = '0;
    for (int unsigned l = 0; l < BB; l++) rl_word[8*l +: 8] = mem[rl_base + MEM_AW'(l)];
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rdata_q <= '0;
      rresp_q <= OKAY;
    end else if (rd_launch) begin
      rdata_q <= rd_oob ? '0 : rl_word;
      rresp_q <= rl_err ? SLVERR : OKAY;
    end
  end

  assign bus.arready = arready;
  assign bus.rvalid  = rvalid;
  assign bus.rlast   = rvalid && rd_last;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;

`ifdef EI_AXI4_SLV_ERR_EN
  assign wr_oob = |wr_addr[ADDR_W-1:MEM_AW];
  assign wr_err = wr_oob || wr_illegal || (bus.wlast != wr_last);
  assign rd_oob = |rl_addr[ADDR_W-1:MEM_AW];
  assign rl_err = rd_oob || rl_illegal;
`else
  logic unused_cfg;
  assign unused_cfg = ^{bus.wlast, wr_illegal, rl_illegal,
                        wr_addr[ADDR_W-1:MEM_AW], rl_addr[ADDR_W-1:MEM_AW]};
  assign wr_oob = 1'b0;
  assign wr_err = 1'b0;
  assign rd_oob = 1'b0;
  assign rl_err = 1'b0;
`endif

endmodule
